serial_demux_n: RTL
===================

Name: serial_demux_n

Overview:
- Parametrised successor to the lab's four-port serial demultiplexer.
- Receives framed serial packets on SerIn and routes the data bits to one of NUM_PORTS output lines.
- Adds a configurable length-field width, an optional even-parity trailer and an out-of-range port error.
- A push-button pulse (ClkPB) arms the receiver for exactly one frame; sits between the board button/switch inputs and the LED/port outputs.

Parameters:
- NUM_PORTS, 4, number of output ports (2..16); PORT_W = clog2(NUM_PORTS), derived localparam.
- LEN_W, 4, width of the length field; the largest frame carries 2^LEN_W-1 data bits.
- PARITY_EN, 1, 1 = one even-parity bit follows the data bits; 0 = no parity bit.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ClkPB  in  1  push-button level; its rising edge arms the receiver.
- SerIn  in  1  serial data, MSB first, sampled every clk.
- Clk_EN  out  1  one-cycle pulse on a detected ClkPB rising edge.
- port_num  out  PORT_W  latched destination port.
- pDcnt  out  LEN_W  data bits remaining in the current frame.
- p  out  NUM_PORTS  demuxed data; p[port_num] = SerIn while serOutvalid, all other bits 0.
- serOutvalid  out  1  high during the data-bit cycles.
- Done  out  1  one-cycle pulse at end of frame.
- par_err  out  1  parity or port-range error of the last frame; sticky until the next arm.

Behaviour:
- Reset:
  - State = IDLE; Clk_EN, Done, serOutvalid, par_err = 0.
  - port_num = 0, pDcnt = 0, p = 0.
  - ClkPB edge-detect register = 0.
- Edge detect:
  - Clk_EN = ClkPB & ~ClkPB_q, where ClkPB_q is ClkPB delayed by one register.
  - Holding ClkPB high gives a single pulse only.
- FSM (registered state; frame-field outputs registered; p and serOutvalid decoded combinationally from state):
  - IDLE: on Clk_EN -> WAIT_START and clear par_err. Clk_EN in any other state is ignored (no re-arm mid-frame).
  - WAIT_START: stay while SerIn = 1; SerIn = 0 -> PORT. No timeout.
  - PORT: PORT_W cycles, shifting SerIn into port_num MSB first -> LEN.
  - LEN: LEN_W cycles, shifting SerIn into pDcnt MSB first.
    - At the last shift, if the assembled value is 0: -> PAR when PARITY_EN, else -> DONE.
    - Otherwise -> DATA.
  - DATA:
    - serOutvalid = 1; p[port_num] = SerIn. If port_num >= NUM_PORTS, p = 0 and par_err is set at frame end.
    - Each cycle pDcnt decrements by 1 and SerIn is XORed into the parity accumulator.
    - When pDcnt = 1 in this cycle: -> PAR if PARITY_EN, else -> DONE. pDcnt reaches 0 on exit.
  - PAR: one cycle; par_err <= par_err | (acc ^ SerIn), i.e. a correct frame has an even count of 1s across data bits plus the parity bit -> DONE.
  - DONE: Done = 1 for one cycle -> IDLE. The receiver needs a new ClkPB edge for the next frame.
- Latency:
  - Clk_EN is one cycle after ClkPB rises.
  - The first data bit appears on p in the same cycle it is on SerIn, which is the (1+PORT_W+LEN_W+1)th sampled cycle after the start bit, counting the start bit as cycle 1.
- Persistence: port_num and pDcnt hold their values after Done until the next frame overwrites them.
- Parity accumulator clears on entry to WAIT_START.
- rst asserted mid-frame aborts the frame in the next cycle, with all outputs at their reset values.
- Simultaneous rst and ClkPB edge: rst wins and Clk_EN stays 0.

Test Plan:
- Defaults, full frame:
  - Stimulus: rst for 5 cycles, then a ClkPB pulse, then SerIn = 0 | 1,0 | 0,0,1,1 | 1,0,1 | 0.
  - Expect: Clk_EN for 1 cycle; port_num = 2; pDcnt counts 3,2,1,0; p = 4'b0100, 0, 4'b0100 during the data cycles; serOutvalid high for 3 cycles; par_err = 0; Done pulse one cycle after the parity bit.
- Parity error:
  - Stimulus: same frame with the parity bit = 1.
  - Expect: Done pulse, par_err = 1, which stays 1 until the next ClkPB arm clears it.
- Zero length:
  - Stimulus: port 1, length 0000, parity 0.
  - Expect: serOutvalid never asserts, p stays 0, Done pulse 1 cycle after the parity bit.
- Not armed / long idle:
  - Stimulus: SerIn toggling with no ClkPB.
  - Expect: state stays IDLE with no outputs.
  - Stimulus: arm, then SerIn = 1 for 20 cycles, then a frame.
  - Expect: the frame decodes correctly.
- Reset mid-DATA:
  - Stimulus: assert rst while pDcnt = 2.
  - Expect: the next cycle has all outputs 0 and state IDLE; a new armed frame decodes normally.
- NUM_PORTS = 3, PARITY_EN = 0:
  - Stimulus: a frame with port 3, length 2.
  - Expect: p stays 0, serOutvalid high for 2 cycles, Done pulse, par_err = 1.

Source files
------------

// File: rtl/serial_demux_n.sv
// serial_demux_n: armed one-shot serial frame receiver that routes
// data bits to one of NUM_PORTS lines, with length field and parity.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   ClkPB        push-button level; rising edge arms one frame
//   SerIn        serial input, MSB first
//   Clk_EN       one-cycle pulse on ClkPB rising edge
//   port_num     latched destination port
//   pDcnt        data bits remaining in current frame
//   p            demuxed data, p[port_num] = SerIn in data cycles
//   serOutvalid  high during data-bit cycles
//   Done         one-cycle end-of-frame pulse
//   par_err      parity / port-range error, sticky until next arm
module serial_demux_n #(
  parameter int NUM_PORTS = 4,
  parameter int LEN_W     = 4,
  parameter int PARITY_EN = 1,
  localparam int PORT_W   = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ClkPB,
  input  logic                 SerIn,
  output logic                 Clk_EN,
  output logic [PORT_W-1:0]    port_num,
  output logic [LEN_W-1:0]     pDcnt,
  output logic [NUM_PORTS-1:0] p,
  output logic                 serOutvalid,
  output logic                 Done,
  output logic                 par_err
);

  localparam int CW = $clog2(PORT_W + LEN_W + 1);
  localparam logic [CW-1:0] PORT_LAST = CW'(PORT_W - 1);
  localparam logic [CW-1:0] LEN_LAST = CW'(LEN_W - 1);
  localparam logic [PORT_W:0] NP = (PORT_W + 1)'(NUM_PORTS);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    PORT,
    LEN,
    DATA,
    PAR,
    DONE
  } state_t;

  state_t            state;
  logic              clk_pb_q;
  logic [CW-1:0]     cnt;
  logic              acc;
  logic              range_err;
  logic [LEN_W-1:0]  len_next;
  logic [PORT_W-1:0] port_next;

  // Non power-of-two port counts leave unreachable port codes.
  assign range_err = {1'b0, port_num} >= NP;
  assign len_next  = (pDcnt << 1) | LEN_W'(SerIn);
  assign port_next = (port_num << 1) | PORT_W'(SerIn);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      clk_pb_q <= 1'b0;
      Clk_EN   <= 1'b0;
      cnt      <= '0;
      acc      <= 1'b0;
      port_num <= '0;
      pDcnt    <= '0;
      Done     <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      clk_pb_q <= ClkPB;
      Clk_EN   <= ClkPB & ~clk_pb_q;
      Done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Clk_EN) begin
            state   <= WAIT_START;
            par_err <= 1'b0;
            acc     <= 1'b0;
          end
        end
        WAIT_START: begin
          if (!SerIn) begin
            state <= PORT;
            cnt   <= '0;
          end
        end
        PORT: begin
          port_num <= port_next;
          if (cnt == PORT_LAST) begin
            cnt   <= '0;
            state <= LEN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LEN: begin
          pDcnt <= len_next;
          if (cnt == LEN_LAST) begin
            cnt <= '0;
            if (len_next != '0) begin
              state <= DATA;
            end else if (PARITY_EN != 0) begin
              state <= PAR;
            end else begin
              state   <= DONE;
              Done    <= 1'b1;
              par_err <= par_err | range_err;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          pDcnt <= pDcnt - 1'b1;
          acc   <= acc ^ SerIn;
          if (pDcnt == LEN_W'(1)) begin
            if (PARITY_EN != 0) begin
              state <= PAR;
            end else begin
              state   <= DONE;
              Done    <= 1'b1;
              par_err <= par_err | range_err;
            end
          end
        end
        PAR: begin
          state   <= DONE;
          Done    <= 1'b1;
          par_err <= par_err | range_err | (acc ^ SerIn);
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    serOutvalid = (state == DATA);
    p = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (serOutvalid && !range_err && port_num == PORT_W'(i)) begin
        p[i] = SerIn;
      end
    end
  end

endmodule
